// File: rtl/posi_ref_fetch.sv
// Reference fetch for the intra predictor: walks the top, left and corner neighbour
// units of a block, reads the available ones from recon and writes all of them to the ref buffer.
module posi_ref_fetch #(
  parameter int PIX_WD = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start_ref_i,
  input  logic [1:0]          size_i,
  input  logic [7:0]          position_i,
  input  logic                lcu_top_avail_i,
  input  logic                lcu_left_avail_i,
  input  logic                lcu_topleft_avail_i,
  input  logic                lcu_topright_avail_i,
  output logic                busy_o,
  output logic                rd_ena_o,
  output logic                rd_sel_o,
  output logic [2:0]          rd_lcu_o,
  output logic [3:0]          rd_bx_o,
  output logic [3:0]          rd_by_o,
  input  logic [4*PIX_WD-1:0] rd_dat_i,
  output logic                ref_wr_ena_o,
  output logic [5:0]          ref_wr_adr_o,
  output logic                ref_wr_avail_o,
  output logic [4*PIX_WD-1:0] ref_wr_dat_o,
  output logic                done_ref_o
);

  typedef enum logic [1:0] {IDLE, TOP, LEFT, CORN} state_t;

  state_t     state;
  logic [1:0] size_q;
  logic [7:0] pos_q;
  logic [3:0] k;

  logic [3:0] x, y, xm1, ym1, last_k;
  logic [4:0] xk, yk, units;
  logic       slot_act, slot_avail;

  function automatic logic [7:0] zscan(input logic [3:0] zx, input logic [3:0] zy);
    return {zy[3], zx[3], zy[2], zx[2], zy[1], zx[1], zy[0], zx[0]};
  endfunction

  assign x      = {pos_q[6], pos_q[4], pos_q[2], pos_q[0]};
  assign y      = {pos_q[7], pos_q[5], pos_q[3], pos_q[1]};
  assign xm1    = x - 4'd1;
  assign ym1    = y - 4'd1;
  assign xk     = {1'b0, x} + {1'b0, k};
  assign yk     = {1'b0, y} + {1'b0, k};
  assign units  = 5'd2 << size_q;
  assign last_k = 4'(units - 5'd1);

  // Slot decode: the read request goes out in the same cycle the slot is evaluated,
  // so recon data lines up with the registered write one cycle later.
  always_comb begin
    slot_act   = 1'b0;
    slot_avail = 1'b0;
    rd_sel_o   = 1'b0;
    rd_lcu_o   = 3'd0;
    rd_bx_o    = 4'd0;
    rd_by_o    = 4'd0;
    case (state)
      TOP: begin
        slot_act = 1'b1;
        rd_bx_o  = xk[3:0];
        rd_by_o  = ym1;
        if (y != 4'd0) begin
          slot_avail = !xk[4] && (zscan(xk[3:0], ym1) < pos_q);
        end else if (!xk[4]) begin
          rd_lcu_o   = 3'd1;
          slot_avail = lcu_top_avail_i;
        end else begin
          rd_lcu_o   = 3'd4;
          slot_avail = lcu_topright_avail_i;
        end
      end
      LEFT: begin
        slot_act = 1'b1;
        rd_sel_o = 1'b1;
        rd_bx_o  = xm1;
        rd_by_o  = yk[3:0];
        if (x != 4'd0) begin
          slot_avail = !yk[4] && (zscan(xm1, yk[3:0]) < pos_q);
        end else begin
          rd_lcu_o   = 3'd2;
          slot_avail = !yk[4] && lcu_left_avail_i;
        end
      end
      CORN: begin
        slot_act = 1'b1;
        rd_bx_o  = xm1;
        rd_by_o  = ym1;
        case ({x == 4'd0, y == 4'd0})
          2'b00: slot_avail = 1'b1;
          2'b10: begin rd_lcu_o = 3'd2; slot_avail = lcu_left_avail_i;    end
          2'b01: begin rd_lcu_o = 3'd1; slot_avail = lcu_top_avail_i;     end
          default: begin rd_lcu_o = 3'd3; slot_avail = lcu_topleft_avail_i; end
        endcase
      end
      default: ;
    endcase
  end

  assign rd_ena_o     = slot_avail;
  assign ref_wr_dat_o = ref_wr_avail_o ? rd_dat_i : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      size_q         <= 2'd0;
      pos_q          <= 8'd0;
      k              <= 4'd0;
      busy_o         <= 1'b0;
      ref_wr_ena_o   <= 1'b0;
      ref_wr_adr_o   <= 6'd0;
      ref_wr_avail_o <= 1'b0;
      done_ref_o     <= 1'b0;
    end else begin
      ref_wr_ena_o   <= slot_act;
      ref_wr_avail_o <= slot_avail;
      done_ref_o     <= (state == CORN);
      case (state)
        TOP:     ref_wr_adr_o <= {2'b00, k};
        LEFT:    ref_wr_adr_o <= {2'b01, k};
        CORN:    ref_wr_adr_o <= 6'd32;
        default: ref_wr_adr_o <= 6'd0;
      endcase
      case (state)
        IDLE: begin
          // busy_o also covers the done cycle, which blocks a back-to-back start there
          if (start_ref_i && !busy_o) begin
            state  <= TOP;
            size_q <= size_i;
            pos_q  <= position_i;
            k      <= 4'd0;
            busy_o <= 1'b1;
          end else if (done_ref_o) begin
            busy_o <= 1'b0;
          end
        end
        TOP: begin
          if (k == last_k) begin
            state <= LEFT;
            k     <= 4'd0;
          end else begin
            k <= k + 4'd1;
          end
        end
        LEFT: begin
          if (k == last_k) begin
            state <= CORN;
            k     <= 4'd0;
          end else begin
            k <= k + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/posi_ref_fetch.md
Name: posi_ref_fetch

Overview:
- Responder on the post-intra controller's reference handshake.
- On each start_ref_i it latches the block size and z-scan position, then computes neighbour availability for every 4-pixel reference unit.
- It reads the available units from the reconstruction buffer and writes all units, with availability flags, into the reference buffer for the intra predictor.
- It pulses done_ref_o on the final write.

Parameters:
- PIX_WD, 8, bits per pixel; one reference unit = 4 pixels = 4*PIX_WD bits.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_ref_i  in  1  single-cycle start pulse
- size_i  in  2  block size: 0=4x4, 1=8x8, 2=16x16, 3=32x32
- position_i  in  8  z-scan index of the block's top-left 4x4 within a 64x64 LCU
- lcu_top_avail_i  in  1  top LCU is reconstructed
- lcu_left_avail_i  in  1  left LCU is reconstructed
- lcu_topleft_avail_i  in  1  top-left LCU is reconstructed
- lcu_topright_avail_i  in  1  top-right LCU is reconstructed
- busy_o  out  1  high from the cycle after start until done_ref_o inclusive
- rd_ena_o  out  1  recon read request
- rd_sel_o  out  1  0 = bottom row of 4x4 block, 1 = right column
- rd_lcu_o  out  3  0 current, 1 top, 2 left, 3 top-left, 4 top-right LCU
- rd_bx_o  out  4  4x4 column inside the addressed LCU
- rd_by_o  out  4  4x4 row inside the addressed LCU
- rd_dat_i  in  4*PIX_WD  recon data, valid exactly 1 cycle after rd_ena_o
- ref_wr_ena_o  out  1  reference-buffer write strobe
- ref_wr_adr_o  out  6  write address: 0..15 top/top-right, 16..31 left/bottom-left, 32 corner
- ref_wr_avail_o  out  1  unit is available
- ref_wr_dat_o  out  4*PIX_WD  rd_dat_i when available, else 0 (combinational)
- done_ref_o  out  1  completion pulse

Behaviour:
- Reset: every registered output is 0, state is IDLE, all counters are 0. Reset asserted mid-operation aborts immediately and no done_ref_o is issued.
- Position decode: x = {p[6],p[4],p[2],p[0]}, y = {p[7],p[5],p[3],p[1]}.
- Define N4 = 1<<size (block width in 4x4 units) and U = 2*N4 units per side.
- Position alignment: the low 2*size bits of position_i must be 0. Behaviour is undefined otherwise.
- FSM: IDLE -> TOP on start_ref_i. TOP issues U slots, k = 0..U-1, then goes to LEFT. LEFT issues U slots, then goes to CORN. CORN issues 1 slot, then goes to IDLE.
- Slot timing: each slot takes exactly one cycle, whether or not a read is issued. Slot s (s = 0..2U) is evaluated in cycle 1+s after the start cycle.
- Write timing: the write for slot s occurs in cycle 2+s. done_ref_o is high in the same cycle as the final write, i.e. cycle 2U+2.
- start_ref_i is ignored while busy_o is high or during the done cycle.
- Top unit k, neighbour at (x+k, y-1):
  - If y>0: the unit is in the current LCU. Available iff x+k<16 and zscan(x+k, y-1) < position.
  - If y==0 and x+k<16: the unit is in the top LCU, available iff lcu_top_avail_i.
  - If y==0 and x+k>=16: the unit is in the top-right LCU at bx=x+k-16, available iff lcu_topright_avail_i.
  - rd_sel_o = 0, rd_by_o = y-1 mod 16.
- Left unit k, neighbour at (x-1, y+k):
  - If x>0: available iff y+k<16 and zscan(x-1, y+k) < position.
  - If x==0: the unit is in the left LCU at bx=15, available iff y+k<16 and lcu_left_avail_i.
  - rd_sel_o = 1.
- Corner, neighbour at (x-1, y-1):
  - Both coordinates in the current LCU: always available.
  - x==0 && y>0: left LCU. x>0 && y==0: top LCU. x==0 && y==0: top-left LCU; availability comes from the matching flag.
  - Read with rd_sel_o = 0.
- Read issue: rd_ena_o is asserted only for available units. Unavailable slots still produce a write with ref_wr_avail_o=0 and data 0.
- Write address: top k -> k; left k -> 16+k; corner -> 32.
- Arithmetic: x+k and y+k are computed 5 bits wide so that the >=16 compare is exact. zscan() re-interleaves 4-bit x/y into an 8-bit index.

Test Plan:
- size 0, position 0, all LCU flags 0 -> no rd_ena_o; 5 writes at adr 0,1,16,17,32, all with avail=0; done_ref_o in cycle 6.
- size 0, position 3 (x=1,y=1) -> top adr0 available, reads (1,0); adr1 unavailable; left adr16 available, reads (0,1); adr17 unavailable; corner reads (0,0) lcu 0; done in cycle 6.
- size 3, position 0, all flags 1 -> 16 top reads with lcu 1, by=15, bx 0..15; 16 left reads with lcu 2, bx=15, by 0..15; corner read lcu 3 (15,15); 33 writes; done in cycle 34.
- size 1, position 0x14 (x=6,y=0), top-right flag 0, top flag 1 -> top k=0..1 available, read from lcu 1; k=2..3 (bx 8,9 <16) also available; lcu_topright is never used; done in cycle 10.
- Drive start_ref_i again in cycle 3 of a size-0 job -> ignored, single done in cycle 6; reset asserted in cycle 4 of a size-2 job -> all outputs 0, no done_ref_o, a new start afterwards runs normally.
